generic_fifo_lvl: RTL and testbench
===================================

GENERIC_FIFO_LVL -- requirements
Module: generic_fifo_lvl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits (legal >= 1).
REQ-002 Parameter DATA_DEPTH, default 8, number of entries; any value >= 2, not restricted to powers of two.
REQ-003 Parameter ALM_FULL_TH, default DATA_DEPTH-1, fill level at which almost_full_o asserts (legal 1..DATA_DEPTH).
REQ-004 Parameter ALM_EMPTY_TH, default 1, fill level at or below which almost_empty_o asserts (legal 0..DATA_DEPTH-1).
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 data_i  input  DATA_WIDTH  push data.
REQ-008 valid_i  input  1  push request.
REQ-009 grant_o  output  1  FIFO can accept; a push occurs when valid_i && grant_o.
REQ-010 data_o  output  DATA_WIDTH  head entry.
REQ-011 valid_o  output  1  head entry valid; a pop occurs when valid_o && grant_i.
REQ-012 grant_i  input  1  pop acknowledge.
REQ-013 flush_i  input  1  synchronous discard of all entries.
REQ-014 test_mode_i  input  1  clock-gate bypass; used only under REQ-033.
REQ-015 fill_o  output  $clog2(DATA_DEPTH+1)  number of valid entries.
REQ-016 almost_full_o / almost_empty_o  output  1 each  threshold flags.

Function
REQ-017 State machine states EMPTY, MIDDLE, FULL; state, push pointer, pop pointer and fill count update together every cycle.
REQ-018 EMPTY: grant_o=1, valid_o=0; push -> MIDDLE (or FULL if DATA_DEPTH==1 is never legal, so always MIDDLE).
REQ-019 MIDDLE: grant_o=1, valid_o=1; push only -> FULL when fill reaches DATA_DEPTH; pop only -> EMPTY when fill reaches 0; push and pop together -> MIDDLE, fill unchanged.
REQ-020 FULL: grant_o=0, valid_o=1; valid_i ignored; pop -> MIDDLE.
REQ-021 Pointers increment by one per operation and wrap from DATA_DEPTH-1 to 0 explicitly (no reliance on natural binary wrap).
REQ-022 fill_o increments on push-only, decrements on pop-only, holds otherwise; never exceeds DATA_DEPTH nor goes below 0.
REQ-023 Latency: data pushed into an empty FIFO appears on data_o with valid_o=1 on the next cycle; no fall-through in the push cycle.
REQ-024 data_o = storage[pop pointer], combinational from registered state; content undefined-stable (last written) when valid_o=0.
REQ-025 almost_full_o = (fill >= ALM_FULL_TH); almost_empty_o = (fill <= ALM_EMPTY_TH); both decoded from registered fill, no input paths.
REQ-026 flush_i=1 has priority over push and pop in the same cycle: next state EMPTY, both pointers 0, fill 0; concurrent push data is discarded, concurrent pop is void; grant_o/valid_o in the flush cycle follow current state.
REQ-027 Storage written only on push (valid_i && grant_o && !flush_i).

Reset
REQ-028 rst_n low asynchronously forces state EMPTY, pointers 0, fill 0, all storage entries 0.
REQ-029 Reset outputs: grant_o=1, valid_o=0, data_o=0, fill_o=0, almost_full_o=0 (given ALM_FULL_TH>=1), almost_empty_o=1.
REQ-030 Reset assertion mid-transfer discards all contents; first cycle after release behaves as EMPTY.

Configuration
REQ-031 Macro GENERIC_FIFO_CLOCK_GATING_EN selects storage clock gating.
REQ-032 Without it: storage clocked directly by clk, test_mode_i unused.
REQ-033 With it: storage clocked by a cluster_clock_gating instance, enable = push condition, test_en = test_mode_i; cycle behaviour identical to REQ-032.

Structure
REQ-034 Package generic_fifo_pkg holds the state enum typedef (EMPTY, MIDDLE, FULL) and a wrap-increment helper function.
REQ-035 No sub-module other than the optional cluster_clock_gating instance; control and storage stay in one module.

Verification
REQ-036 DATA_DEPTH=5: push 5 words 0x1..0x5 with grant_i=0 -> grant_o=0 after 5th, fill_o=5, almost_full_o=1; 6th push ignored.
REQ-037 Drain from full with grant_i=1 -> data_o 0x1..0x5 in order, then valid_o=0, fill_o=0, almost_empty_o=1.
REQ-038 Continuous push+pop for 3*DATA_DEPTH cycles at fill 2 -> fill_o constant 2, in-order data, pointers wrap past index 4 correctly.
REQ-039 Flush with fill=3 concurrent with push of 0xAA and pop -> next cycle fill_o=0, valid_o=0; 0xAA never appears.
REQ-040 rst_n low for one cycle mid-stream at fill=4 -> outputs per REQ-029 immediately; run once per macro setting with identical results.

Source files
------------

// File: rtl/generic_fifo_pkg.sv
// Shared types and helpers for the level-tracking generic FIFO.
package generic_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    MIDDLE = 2'd1,
    FULL   = 2'd2
  } fifo_state_e;

  // Increment a pointer and wrap explicitly at depth-1, valid for any depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/cluster_clock_gating.sv
// Latch-based integrated clock gate, only built when GENERIC_FIFO_CLOCK_GATING_EN is defined.
`ifdef GENERIC_FIFO_CLOCK_GATING_EN
module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latch;

  // Transparent while clk is low so the enable is stable across the high phase.
  always_latch begin
    if (!clk_i) en_latch = en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latch;

endmodule
`endif

// File: rtl/generic_fifo_lvl.sv
// FIFO with EMPTY/MIDDLE/FULL control, fill level and threshold flags.
// GENERIC_FIFO_CLOCK_GATING_EN selects a gated clock for the storage array.
module generic_fifo_lvl
  import generic_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DATA_DEPTH   = 8,
  parameter int unsigned ALM_FULL_TH  = DATA_DEPTH - 1,
  parameter int unsigned ALM_EMPTY_TH = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              data_i,
  input  logic                               valid_i,
  output logic                               grant_o,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic                               valid_o,
  input  logic                               grant_i,
  input  logic                               flush_i,
  input  logic                               test_mode_i,
  output logic [$clog2(DATA_DEPTH+1)-1:0]    fill_o,
  output logic                               almost_full_o,
  output logic                               almost_empty_o
);

  localparam int unsigned PTR_W  = $clog2(DATA_DEPTH);
  localparam int unsigned FILL_W = $clog2(DATA_DEPTH + 1);

  fifo_state_e        state_q, state_d;
  logic [PTR_W-1:0]   push_ptr_q, push_ptr_d;
  logic [PTR_W-1:0]   pop_ptr_q, pop_ptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  logic push, pop, wr_en, mem_clk;

  assign grant_o = (state_q != FULL);
  assign valid_o = (state_q != EMPTY);
  assign push    = valid_i && grant_o;
  assign pop     = valid_o && grant_i;
  assign wr_en   = push && !flush_i;

  assign data_o         = mem_q[pop_ptr_q];
  assign fill_o         = fill_q;
  assign almost_full_o  = (32'(fill_q) >= ALM_FULL_TH);
  assign almost_empty_o = (32'(fill_q) <= ALM_EMPTY_TH);

  // Control state: state, pointers and fill move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      push_ptr_q <= '0;
      pop_ptr_q  <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      push_ptr_q <= push_ptr_d;
      pop_ptr_q  <= pop_ptr_d;
      fill_q     <= fill_d;
    end
  end

  // Next-state decode; flush overrides any concurrent push or pop.
  always_comb begin
    state_d    = state_q;
    push_ptr_d = push_ptr_q;
    pop_ptr_d  = pop_ptr_q;
    fill_d     = fill_q;
    if (flush_i) begin
      state_d    = EMPTY;
      push_ptr_d = '0;
      pop_ptr_d  = '0;
      fill_d     = '0;
    end else begin
      if (push) push_ptr_d = PTR_W'(wrap_inc(32'(push_ptr_q), DATA_DEPTH));
      if (pop)  pop_ptr_d  = PTR_W'(wrap_inc(32'(pop_ptr_q), DATA_DEPTH));
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = MIDDLE;
            fill_d  = fill_q + FILL_W'(1);
          end
        end
        MIDDLE: begin
          if (push && !pop) begin
            fill_d = fill_q + FILL_W'(1);
            if (32'(fill_q) == DATA_DEPTH - 1) state_d = FULL;
          end else if (pop && !push) begin
            fill_d = fill_q - FILL_W'(1);
            if (fill_q == FILL_W'(1)) state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = MIDDLE;
            fill_d  = fill_q - FILL_W'(1);
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef GENERIC_FIFO_CLOCK_GATING_EN
  cluster_clock_gating u_cg (
    .clk_i     (clk),
    .en_i      (wr_en),
    .test_en_i (test_mode_i),
    .clk_o     (mem_clk)
  );
`else
  logic test_mode_unused;
  assign test_mode_unused = test_mode_i;
  assign mem_clk          = clk;
`endif

  // Storage array, written only on an accepted, non-flushed push.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DATA_DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[push_ptr_q] <= data_i;
    end
  end

endmodule

// File: tb/tb_generic_fifo_lvl.sv
// Self-checking bench for generic_fifo_lvl against a queue-based reference model.
module tb_generic_fifo_lvl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned AF_TH = DEPTH - 1;
  localparam int unsigned AE_TH = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          grant_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          grant_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          test_mode_i = 1'b0;
  logic [2:0]    fill_o;
  logic          almost_full_o;
  logic          almost_empty_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] q[$];
  bit seen_aa;

  generic_fifo_lvl #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .grant_o        (grant_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .grant_i        (grant_i),
    .flush_i        (flush_i),
    .test_mode_i    (test_mode_i),
    .fill_o         (fill_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs to what the queue model implies.
  task automatic check(input string tag);
    int n;
    n = q.size();
    chk({tag, ".fill"},  32'(fill_o), 32'(n));
    chk({tag, ".valid"}, 32'(valid_o), 32'(n > 0));
    chk({tag, ".grant"}, 32'(grant_o), 32'(n < int'(DEPTH)));
    chk({tag, ".afull"}, 32'(almost_full_o), 32'(n >= int'(AF_TH)));
    chk({tag, ".aempty"}, 32'(almost_empty_o), 32'(n <= int'(AE_TH)));
    if (n > 0) begin
      chk({tag, ".data"}, 32'(data_o), 32'(q[0]));
      if (q[0] == 8'hAA) seen_aa = 1'b1;
    end
  endtask

  // One cycle: check at negedge, drive, advance model across posedge.
  task automatic cyc(input string tag, input logic v, input logic [DW-1:0] d,
                     input logic g, input logic f);
    bit do_push, do_pop;
    check(tag);
    valid_i = v; data_i = d; grant_i = g; flush_i = f;
    do_push = v && (q.size() < int'(DEPTH));
    do_pop  = g && (q.size() > 0);
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    seen_aa = 1'b0;
    // Reset values
    #2;
    check("rst");
    chk("rst.data", 32'(data_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill to full, sixth push must be dropped
    for (int i = 1; i <= 5; i++) cyc("fill", 1'b1, DW'(i), 1'b0, 1'b0);
    cyc("full", 1'b1, 8'h66, 1'b0, 1'b0);
    check("full_hold");

    // Drain in order
    for (int i = 0; i < 6; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drained");

    // Steady push+pop at fill 2 with pointer wrap
    cyc("pre2", 1'b1, 8'h21, 1'b0, 1'b0);
    cyc("pre2", 1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 3 * int'(DEPTH); i++)
      cyc("stream", 1'b1, DW'($urandom_range(0, 8'h9F)), 1'b1, 1'b0);
    check("stream_end");

    // Flush at fill 3 while pushing 0xAA and popping
    cyc("pre_fl", 1'b1, 8'h31, 1'b0, 1'b0);
    chk("pre_fl.fill3", 32'(fill_o), 32'd3);
    cyc("flush", 1'b1, 8'hAA, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc("post_fl", 1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("post_fl_dr", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("no_aa", 32'(seen_aa), 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      cyc("rand", 1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 40) == 0));

    // Mid-stream asynchronous reset at fill 4
    cyc("flush2", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc("pre_rst", 1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
    chk("pre_rst.fill4", 32'(fill_o), 32'd4);
    valid_i = 1'b0; grant_i = 1'b0; flush_i = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst");
    chk("mid_rst.data", 32'(data_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++)
      cyc("post_rst", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
